// File: rtl/ariane_pkg.sv
// ariane_pkg (slice)
// Purpose : the subset of the core-wide ariane package that the writeback
//           arbiter depends on: the scoreboard transaction-id width and the
//           exception record carried alongside every functional-unit result.
// Ports   : none (package).
package ariane_pkg;

  localparam int unsigned NR_SB_ENTRIES = 8;
  localparam int unsigned TRANS_ID_BITS = $clog2(NR_SB_ENTRIES);

  typedef struct packed {
    logic [63:0] cause;
    logic [63:0] tval;
    logic        valid;
  } exception_t;

endpackage

// File: rtl/flu_wb_arbiter_pkg.sv
// flu_wb_arbiter_pkg
// Purpose : shared constants and helpers for the FLU writeback arbiter.
//           No data types live here; records come from ariane_pkg.
// Ports   : none (package).
package flu_wb_arbiter_pkg;

  // Upper bound on the channel count; helpers take vectors of this width.
  localparam int unsigned FLU_MAX_CH = 8;

  // Saturation value of the contention counter.
  localparam logic [31:0] FLU_CNT_SAT = 32'hFFFF_FFFF;

  // True when at least two bits of v are set (two or more channels waiting).
  function automatic logic multi_pending(input logic [FLU_MAX_CH-1:0] v);
    logic [3:0] ones;
    ones = 4'd0;
    for (int i = 0; i < FLU_MAX_CH; i++) begin
      ones = ones + {3'd0, v[i]};
    end
    return (ones >= 4'd2);
  endfunction

endpackage

// File: rtl/flu_wb_fifo.sv
// flu_wb_fifo
// Purpose : per-channel result buffer of DEPTH entries. Full/empty come only
//           from the registered count, so a pop never frees space for a push
//           within the same cycle. Push and pop together keep the count.
// Ports   : clk_i, rst_i (async, active-high), flush_i (sync clear, discards
//           that cycle's push/pop), push_i, pop_i, data_i -> entry in,
//           data_o -> head entry, empty_o / full_o -> occupancy flags.
module flu_wb_fifo #(
  parameter int unsigned DATA_W = 64,
  parameter int unsigned DEPTH  = 2
) (
  input  logic              clk_i,
  input  logic              rst_i,
  input  logic              flush_i,
  input  logic              push_i,
  input  logic              pop_i,
  input  logic [DATA_W-1:0] data_i,
  output logic [DATA_W-1:0] data_o,
  output logic              empty_o,
  output logic              full_o
);

  localparam int unsigned PTR_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam int unsigned CNT_W = $clog2(DEPTH + 1);

  logic [DATA_W-1:0] mem_q [DEPTH];
  logic [PTR_W-1:0]  rd_q, rd_d, wr_q, wr_d;
  logic [CNT_W-1:0]  cnt_q, cnt_d;
  logic              do_push_s, do_pop_s;

  // Wrap at DEPTH-1 explicitly so a single-entry buffer keeps its pointer at 0.
  function automatic logic [PTR_W-1:0] ptr_inc(input logic [PTR_W-1:0] p);
    if (p == PTR_W'(DEPTH - 1)) begin
      return '0;
    end else begin
      return p + PTR_W'(1);
    end
  endfunction

  assign empty_o   = (cnt_q == CNT_W'(0));
  assign full_o    = (cnt_q == CNT_W'(DEPTH));
  assign data_o    = mem_q[rd_q];
  assign do_push_s = push_i & ~full_o & ~flush_i;
  assign do_pop_s  = pop_i & ~empty_o & ~flush_i;

  // Next-state for pointers and occupancy.
  always_comb begin
    rd_d  = rd_q;
    wr_d  = wr_q;
    cnt_d = cnt_q;
    if (flush_i) begin
      rd_d  = '0;
      wr_d  = '0;
      cnt_d = '0;
    end else begin
      if (do_push_s) begin
        wr_d = ptr_inc(wr_q);
      end else begin
        wr_d = wr_q;
      end
      if (do_pop_s) begin
        rd_d = ptr_inc(rd_q);
      end else begin
        rd_d = rd_q;
      end
      case ({do_push_s, do_pop_s})
        2'b10:   cnt_d = cnt_q + CNT_W'(1);
        2'b01:   cnt_d = cnt_q - CNT_W'(1);
        default: cnt_d = cnt_q;
      endcase
    end
  end

  // Pointer/count registers.
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      rd_q  <= '0;
      wr_q  <= '0;
      cnt_q <= '0;
    end else begin
      rd_q  <= rd_d;
      wr_q  <= wr_d;
      cnt_q <= cnt_d;
    end
  end

  // Entry storage; contents beyond the count are never observed.
  always_ff @(posedge clk_i) begin
    if (do_push_s) begin
      mem_q[wr_q] <= data_i;
    end
  end

endmodule

// File: rtl/flu_wb_arbiter.sv
// flu_wb_arbiter
// Purpose : collects results from NR_CH functional-unit channels, buffers
//           each in a flu_wb_fifo and writes them back one per cycle using a
//           round-robin grant. A stalled grant is locked until accepted.
// Ports   : clk_i, rst_i (async, active-high), flush_i (sync clear);
//           ch_valid_i/ch_ready_o/ch_result_i/ch_trans_id_i/ch_ex_i -> per-
//           channel push side; wb_valid_o/wb_ready_i/wb_result_o/
//           wb_trans_id_o/wb_ex_o/wb_ch_o -> writeback side;
//           conflict_cnt_o -> cycles with two or more channels waiting.
// Config  : define FLU_WB_ARB_PERF_EN to build the contention counter;
//           otherwise conflict_cnt_o is tied to zero.
module flu_wb_arbiter
  import ariane_pkg::*;
  import flu_wb_arbiter_pkg::*;
#(
  parameter int unsigned NR_CH  = 4,
  parameter int unsigned DATA_W = 64,
  parameter int unsigned DEPTH  = 2,
  parameter int unsigned TID_W  = ariane_pkg::TRANS_ID_BITS
) (
  input  logic                           clk_i,
  input  logic                           rst_i,
  input  logic                           flush_i,
  input  logic [NR_CH-1:0]               ch_valid_i,
  output logic [NR_CH-1:0]               ch_ready_o,
  input  logic [NR_CH-1:0][DATA_W-1:0]   ch_result_i,
  input  logic [NR_CH-1:0][TID_W-1:0]    ch_trans_id_i,
  input  exception_t [NR_CH-1:0]         ch_ex_i,
  output logic                           wb_valid_o,
  input  logic                           wb_ready_i,
  output logic [DATA_W-1:0]              wb_result_o,
  output logic [TID_W-1:0]               wb_trans_id_o,
  output exception_t                     wb_ex_o,
  output logic [$clog2(NR_CH)-1:0]       wb_ch_o,
  output logic [31:0]                    conflict_cnt_o
);

  localparam int unsigned CH_W    = $clog2(NR_CH);
  localparam int unsigned EX_W    = $bits(exception_t);
  localparam int unsigned ENTRY_W = DATA_W + TID_W + EX_W;

  logic [NR_CH-1:0]   empty_s, full_s, push_s, pop_s;
  logic [ENTRY_W-1:0] head_s [NR_CH];
  logic [ENTRY_W-1:0] head_sel_s;
  logic [CH_W-1:0]    rr_ptr_q, rr_ptr_d, lock_ch_q, lock_ch_d;
  logic [CH_W-1:0]    rr_grant_s, sel_s;
  logic               locked_q, locked_d, any_valid_s, accept_s;

  for (genvar i = 0; i < NR_CH; i++) begin : g_ch
    flu_wb_fifo #(
      .DATA_W (ENTRY_W),
      .DEPTH  (DEPTH)
    ) u_fifo (
      .clk_i   (clk_i),
      .rst_i   (rst_i),
      .flush_i (flush_i),
      .push_i  (push_s[i]),
      .pop_i   (pop_s[i]),
      .data_i  ({ch_result_i[i], ch_trans_id_i[i], ch_ex_i[i]}),
      .data_o  (head_s[i]),
      .empty_o (empty_s[i]),
      .full_o  (full_s[i])
    );
  end

  assign ch_ready_o  = ~full_s;
  assign push_s      = ch_valid_i & ~full_s & {NR_CH{~flush_i}};
  assign any_valid_s = ~(&empty_s);
  assign accept_s    = any_valid_s & wb_ready_i & ~flush_i;
  // A grant left unaccepted last cycle stays put so wb_* cannot change under stall.
  assign sel_s       = locked_q ? lock_ch_q : rr_grant_s;
  assign head_sel_s  = head_s[sel_s];

  // Round-robin search: first non-empty channel at or after rr_ptr_q.
  always_comb begin
    int unsigned idx_v;
    logic        found_v;
    idx_v      = 0;
    found_v    = 1'b0;
    rr_grant_s = rr_ptr_q;
    for (int k = 0; k < NR_CH; k++) begin
      idx_v = 32'(rr_ptr_q) + 32'(k);
      if (idx_v >= NR_CH) begin
        idx_v = idx_v - NR_CH;
      end else begin
        idx_v = idx_v;
      end
      if (!found_v && !empty_s[CH_W'(idx_v)]) begin
        rr_grant_s = CH_W'(idx_v);
        found_v    = 1'b1;
      end else begin
        found_v    = found_v;
      end
    end
  end

  // Pop strobe to the granted buffer.
  always_comb begin
    pop_s = '0;
    if (accept_s) begin
      pop_s[sel_s] = 1'b1;
    end else begin
      pop_s = '0;
    end
  end

  // Writeback fields, forced to zero when nothing is pending.
  always_comb begin
    wb_valid_o    = any_valid_s;
    wb_result_o   = '0;
    wb_trans_id_o = '0;
    wb_ex_o       = '0;
    wb_ch_o       = '0;
    if (any_valid_s) begin
      wb_result_o   = head_sel_s[ENTRY_W-1 -: DATA_W];
      wb_trans_id_o = head_sel_s[EX_W +: TID_W];
      wb_ex_o       = exception_t'(head_sel_s[EX_W-1:0]);
      wb_ch_o       = sel_s;
    end else begin
      wb_ch_o       = '0;
    end
  end

  // Arbitration state next-values.
  always_comb begin
    rr_ptr_d  = rr_ptr_q;
    locked_d  = any_valid_s & ~wb_ready_i & ~flush_i;
    lock_ch_d = sel_s;
    if (flush_i) begin
      rr_ptr_d = '0;
    end else if (accept_s) begin
      rr_ptr_d = (sel_s == CH_W'(NR_CH - 1)) ? '0 : sel_s + CH_W'(1);
    end else begin
      rr_ptr_d = rr_ptr_q;
    end
  end

  // Arbitration state registers.
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      rr_ptr_q  <= '0;
      locked_q  <= 1'b0;
      lock_ch_q <= '0;
    end else begin
      rr_ptr_q  <= rr_ptr_d;
      locked_q  <= locked_d;
      lock_ch_q <= lock_ch_d;
    end
  end

`ifdef FLU_WB_ARB_PERF_EN
  logic [31:0]           conflict_q, conflict_d;
  logic [FLU_MAX_CH-1:0] busy_ext_s;

  // Saturating count of cycles where two or more channels are waiting.
  always_comb begin
    busy_ext_s              = '0;
    busy_ext_s[NR_CH-1:0]   = ~empty_s;
    if (multi_pending(busy_ext_s) && (conflict_q != FLU_CNT_SAT)) begin
      conflict_d = conflict_q + 32'd1;
    end else begin
      conflict_d = conflict_q;
    end
  end

  // Contention counter register; flush does not touch it.
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      conflict_q <= 32'd0;
    end else begin
      conflict_q <= conflict_d;
    end
  end

  assign conflict_cnt_o = conflict_q;
`else
  assign conflict_cnt_o = 32'd0;
`endif

endmodule

// File: tb/tb_flu_wb_arbiter.sv
// tb_flu_wb_arbiter
// Purpose : self-checking bench for flu_wb_arbiter (NR_CH=4, DEPTH=2).
//           Expected writebacks are queued in grant order when stimulus is
//           driven and compared as the DUT hands them over.
// Ports   : none (top-level bench).
module tb_flu_wb_arbiter;
  import ariane_pkg::*;

  localparam int NR_CH  = 4;
  localparam int DATA_W = 64;
  localparam int DEPTH  = 2;
  localparam int TID_W  = ariane_pkg::TRANS_ID_BITS;
`ifdef FLU_WB_ARB_PERF_EN
  localparam bit PERF = 1'b1;
`else
  localparam bit PERF = 1'b0;
`endif

  typedef struct {
    logic [1:0]       ch;
    logic [63:0]      res;
    logic [TID_W-1:0] tid;
  } exp_t;

  logic                         clk_i = 1'b0;
  logic                         rst_i = 1'b1;
  logic                         flush_i;
  logic [NR_CH-1:0]             ch_valid_i;
  logic [NR_CH-1:0]             ch_ready_o;
  logic [NR_CH-1:0][DATA_W-1:0] ch_result_i;
  logic [NR_CH-1:0][TID_W-1:0]  ch_trans_id_i;
  exception_t [NR_CH-1:0]       ch_ex_i;
  logic                         wb_valid_o;
  logic                         wb_ready_i;
  logic [DATA_W-1:0]            wb_result_o;
  logic [TID_W-1:0]             wb_trans_id_o;
  exception_t                   wb_ex_o;
  logic [1:0]                   wb_ch_o;
  logic [31:0]                  conflict_cnt_o;

  int   checks = 0;
  int   errors = 0;
  exp_t exp_q[$];
  exp_t mon_e;

  flu_wb_arbiter #(
    .NR_CH(NR_CH), .DATA_W(DATA_W), .DEPTH(DEPTH), .TID_W(TID_W)
  ) dut (
    .clk_i(clk_i), .rst_i(rst_i), .flush_i(flush_i),
    .ch_valid_i(ch_valid_i), .ch_ready_o(ch_ready_o),
    .ch_result_i(ch_result_i), .ch_trans_id_i(ch_trans_id_i), .ch_ex_i(ch_ex_i),
    .wb_valid_o(wb_valid_o), .wb_ready_i(wb_ready_i),
    .wb_result_o(wb_result_o), .wb_trans_id_o(wb_trans_id_o), .wb_ex_o(wb_ex_o),
    .wb_ch_o(wb_ch_o), .conflict_cnt_o(conflict_cnt_o)
  );

  always #5 clk_i = ~clk_i;

  task automatic check_val(input string tag, input logic [63:0] got, input logic [63:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  task automatic cyc();
    @(posedge clk_i);
    #1;
  endtask

  task automatic drive(input int ch, input logic [63:0] res, input logic [TID_W-1:0] tid);
    ch_valid_i[ch]          = 1'b1;
    ch_result_i[ch]         = res;
    ch_trans_id_i[ch]       = tid;
    ch_ex_i[ch]             = '0;
    ch_ex_i[ch].cause       = res ^ 64'h55;
  endtask

  task automatic sb_expect(input int ch, input logic [63:0] res, input logic [TID_W-1:0] tid);
    exp_t e;
    e.ch  = 2'(ch);
    e.res = res;
    e.tid = tid;
    exp_q.push_back(e);
  endtask

  task automatic drain();
    for (int i = 0; i < 32; i++) begin
      if (exp_q.size() == 0) break;
      @(negedge clk_i);
      #1;
    end
    check_val("drain", 64'(exp_q.size()), 64'd0);
  endtask

  // Scoreboard monitor: every accepted writeback must match the queue head.
  always @(negedge clk_i) begin
    if (!rst_i && !flush_i && wb_valid_o && wb_ready_i) begin
      if (exp_q.size() == 0) begin
        check_val("sb_unexpected", 64'd1, 64'd0);
      end else begin
        mon_e = exp_q.pop_front();
        check_val("wb_ch", 64'(wb_ch_o), 64'(mon_e.ch));
        check_val("wb_result", wb_result_o, mon_e.res);
        check_val("wb_tid", 64'(wb_trans_id_o), 64'(mon_e.tid));
        check_val("wb_ex_cause", wb_ex_o.cause, mon_e.res ^ 64'h55);
      end
    end
  end

  initial begin
    #200000;
    $display("FAIL watchdog got=timeout exp=finish");
    $fatal(1, "watchdog expired");
  end

  initial begin
    flush_i = 1'b0; wb_ready_i = 1'b0; ch_valid_i = '0;
    ch_result_i = '0; ch_trans_id_i = '0; ch_ex_i = '0;

    // Reset state
    repeat (2) @(negedge clk_i);
    check_val("rst_valid", 64'(wb_valid_o), 64'd0);
    check_val("rst_ready", 64'(ch_ready_o), 64'hF);
    check_val("rst_cnt", 64'(conflict_cnt_o), 64'd0);
    check_val("rst_res", wb_result_o, 64'd0);
    cyc(); rst_i = 1'b0;

    // Single channel, one-cycle latency
    wb_ready_i = 1'b1;
    drive(2, 64'hDEAD, 3); sb_expect(2, 64'hDEAD, 3);
    @(negedge clk_i); check_val("lat_push_cycle", 64'(wb_valid_o), 64'd0);
    cyc(); ch_valid_i = '0;
    @(negedge clk_i);
    check_val("single_valid", 64'(wb_valid_o), 64'd1);
    check_val("single_ch", 64'(wb_ch_o), 64'd2);
    cyc();
    @(negedge clk_i);
    check_val("idle_valid", 64'(wb_valid_o), 64'd0);
    check_val("idle_res", wb_result_o, 64'd0);
    check_val("idle_ch", 64'(wb_ch_o), 64'd0);

    // Empty flush brings rr_ptr back to 0
    cyc(); flush_i = 1'b1;
    cyc(); flush_i = 1'b0;

    // Fairness: all four at once -> ch0..ch3
    for (int i = 0; i < NR_CH; i++) drive(i, 64'h100 + 64'(i), TID_W'(i));
    for (int i = 0; i < NR_CH; i++) sb_expect(i, 64'h100 + 64'(i), TID_W'(i));
    cyc(); ch_valid_i = '0;
    drain();
    check_val("fair_conflict", 64'(conflict_cnt_o), PERF ? 64'd3 : 64'd0);

    // Backpressure on ch1 with a late ch0 arrival that must not steal the grant
    cyc(); wb_ready_i = 1'b0; drive(1, 64'hA1, 1); sb_expect(1, 64'hA1, 1);
    @(negedge clk_i); check_val("bp_ready_first", 64'(ch_ready_o[1]), 64'd1);
    cyc(); drive(1, 64'hA2, 2);
    @(negedge clk_i);
    check_val("bp_valid", 64'(wb_valid_o), 64'd1);
    check_val("bp_ch", 64'(wb_ch_o), 64'd1);
    check_val("bp_res_a", wb_result_o, 64'hA1);
    cyc(); drive(1, 64'hA3, 3);
    @(negedge clk_i);
    check_val("bp_full", 64'(ch_ready_o[1]), 64'd0);
    check_val("bp_res_b", wb_result_o, 64'hA1);
    cyc(); drive(0, 64'hB0, 4); sb_expect(0, 64'hB0, 4); sb_expect(1, 64'hA2, 2);
    @(negedge clk_i);
    check_val("bp_lock_ch", 64'(wb_ch_o), 64'd1);
    check_val("bp_res_c", wb_result_o, 64'hA1);
    cyc(); ch_valid_i[0] = 1'b0; wb_ready_i = 1'b1;
    @(negedge clk_i); check_val("bp_no_passthru", 64'(ch_ready_o[1]), 64'd0);
    cyc(); sb_expect(1, 64'hA3, 3);
    @(negedge clk_i); check_val("bp_ready_again", 64'(ch_ready_o[1]), 64'd1);
    cyc(); ch_valid_i = '0;
    drain();

    // Flush with two entries in ch0 and ch3; ch1 push in the flush cycle is dropped
    cyc(); wb_ready_i = 1'b0; drive(0, 64'hC0, 5); drive(3, 64'hC3, 6);
    cyc(); drive(0, 64'hC1, 5); drive(3, 64'hC4, 6);
    cyc(); ch_valid_i = '0; drive(1, 64'hD1, 7); flush_i = 1'b1; wb_ready_i = 1'b1;
    cyc(); flush_i = 1'b0; ch_valid_i = '0; wb_ready_i = 1'b0;
    @(negedge clk_i);
    check_val("fl_valid", 64'(wb_valid_o), 64'd0);
    check_val("fl_ready", 64'(ch_ready_o), 64'hF);
    check_val("fl_res", wb_result_o, 64'd0);
    check_val("fl_conflict", 64'(conflict_cnt_o), PERF ? 64'd7 : 64'd0);

    // rr_ptr is 0 after flush: ch1 before ch3
    cyc(); wb_ready_i = 1'b1; drive(1, 64'hE1, 1); drive(3, 64'hE3, 2);
    sb_expect(1, 64'hE1, 1); sb_expect(3, 64'hE3, 2);
    cyc(); ch_valid_i = '0;
    drain();

    // Wrap: grant ch2 -> rr_ptr 3; ch0+ch3 pending -> ch3 then ch0
    cyc(); drive(2, 64'hF2, 3); sb_expect(2, 64'hF2, 3);
    cyc(); ch_valid_i = '0;
    drain();
    cyc(); drive(0, 64'h60, 4); drive(3, 64'h63, 5);
    sb_expect(3, 64'h63, 5); sb_expect(0, 64'h60, 4);
    cyc(); ch_valid_i = '0;
    drain();

    // Asynchronous reset in the middle of buffered traffic
    cyc(); wb_ready_i = 1'b0;
    for (int i = 0; i < NR_CH; i++) drive(i, 64'h700 + 64'(i), TID_W'(i));
    cyc(); ch_valid_i = '0;
    @(negedge clk_i);
    check_val("rm_pre_valid", 64'(wb_valid_o), 64'd1);
    #2 rst_i = 1'b1;
    #1;
    check_val("rm_valid", 64'(wb_valid_o), 64'd0);
    check_val("rm_ready", 64'(ch_ready_o), 64'hF);
    check_val("rm_conflict", 64'(conflict_cnt_o), 64'd0);
    check_val("rm_res", wb_result_o, 64'd0);
    cyc(); rst_i = 1'b0; wb_ready_i = 1'b1;
    @(negedge clk_i);
    check_val("rm_dropped", 64'(wb_valid_o), 64'd0);
    check_val("sb_leftover", 64'(exp_q.size()), 64'd0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
